// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe.
// master = beat source and result sink, slave = the adder.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH split into STAGES segments, BLOCK-grouped lookahead per segment.
// Define CLA_SAT_EN to saturate the sum as signed two's complement on overflow.
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic            clk,
    input  logic            rst,
    cla_adder_pipe_if.slave bus
);
    localparam int SEG     = WIDTH / STAGES;
    localparam int NGRP    = (SEG + BLOCK - 1) / BLOCK;
    localparam int LO_BITS = SEG * STAGES * (STAGES + 1) / 2;
    localparam int OP_BITS = SEG * STAGES * (STAGES - 1) / 2;
    localparam int OPW     = (OP_BITS > 0) ? OP_BITS : 1;

    if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > 8 || BLOCK < 1) begin : g_bad_params
        $error("cla_adder_pipe: illegal WIDTH/STAGES/BLOCK combination");
    end

    // Bit offset of rank k's skewed operand field inside the flat operand vectors.
    function automatic int op_off(input int k);
        return SEG * (k * (STAGES - 1) - (k * (k - 1)) / 2);
    endfunction

    // Two-level lookahead over one segment: group G/P resolve group carries, bits ripple inside a group.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                             input logic cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] s;
        logic [NGRP:0]  cg;
        logic           gg;
        logic           pp;
        logic           c;
        int             idx;
        g     = x & y;
        p     = x ^ y;
        s     = '0;
        cg    = '0;
        cg[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                idx = j * BLOCK + i;
                if (idx < SEG) begin
                    gg = g[idx] | (p[idx] & gg);
                    pp = pp & p[idx];
                end
            end
            cg[j+1] = gg | (pp & cg[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            c = cg[j];
            for (int i = 0; i < BLOCK; i++) begin
                idx = j * BLOCK + i;
                if (idx < SEG) begin
                    s[idx] = p[idx] ^ c;
                    c      = g[idx] | (p[idx] & c);
                end
            end
        end
        return {cg[NGRP], s};
    endfunction

    logic               advance;
    logic               in_fire;
    logic               c_eff;
    logic [WIDTH-1:0]   b_eff;
    logic [STAGES-1:0]  vld_q;
    logic [STAGES-1:0]  vld_d;
    logic [STAGES-1:0]  cy_q;
    logic [STAGES-1:0]  cy_d;
    logic [LO_BITS-1:0] lo_q;
    logic [LO_BITS-1:0] lo_d;
    logic [OPW-1:0]     opa_q;
    logic [OPW-1:0]     opa_d;
    logic [OPW-1:0]     opb_q;
    logic [OPW-1:0]     opb_d;
    logic               ov_q;
    logic               ov_d;

    assign advance = !vld_q[STAGES-1] || bus.out_ready;
    assign in_fire = bus.in_valid && advance;
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign c_eff   = bus.carry_in ^ bus.sub;

    // Rank k holds the finished low (k+1)*SEG sum bits, the carry out of segment k and the untouched upper operands.
    for (genvar k = 0; k < STAGES; k++) begin : g_rank
        localparam int LW    = (k + 1) * SEG;
        localparam int LOFF  = SEG * k * (k + 1) / 2;
        localparam int PLOFF = (k > 0) ? SEG * (k - 1) * k / 2 : 0;
        localparam int POFF  = (k > 0) ? op_off(k - 1) : 0;
        localparam int OOFF  = op_off(k);
        localparam int OW    = SEG * (STAGES - 1 - k);

        logic [SEG-1:0] sa;
        logic [SEG-1:0] sb;
        logic [SEG-1:0] ss;
        logic           sc;
        logic           sco;
        logic           en;
        logic [LW-1:0]  lo_new;

        if (k == 0) begin : g_head
            assign sa       = bus.a[SEG-1:0];
            assign sb       = b_eff[SEG-1:0];
            assign sc       = c_eff;
            assign lo_new   = ss;
            assign vld_d[k] = in_fire;
        end else begin : g_body
            assign sa       = opa_q[POFF +: SEG];
            assign sb       = opb_q[POFF +: SEG];
            assign sc       = cy_q[k-1];
            assign lo_new   = {ss, lo_q[PLOFF +: k*SEG]};
            assign vld_d[k] = vld_q[k-1];
        end

        assign {sco, ss} = cla_seg(sa, sb, sc);
        // Ranks only capture real beats so the output holds its last result across bubbles.
        assign en        = advance && vld_d[k];
        assign cy_d[k]   = en ? sco : cy_q[k];

        if (k < STAGES - 1) begin : g_skew
            if (k == 0) begin : g_load
                assign opa_d[OOFF +: OW] = en ? bus.a[WIDTH-1:SEG] : opa_q[OOFF +: OW];
                assign opb_d[OOFF +: OW] = en ? b_eff[WIDTH-1:SEG] : opb_q[OOFF +: OW];
            end else begin : g_pass
                assign opa_d[OOFF +: OW] = en ? opa_q[POFF+SEG +: OW] : opa_q[OOFF +: OW];
                assign opb_d[OOFF +: OW] = en ? opb_q[POFF+SEG +: OW] : opb_q[OOFF +: OW];
            end
            assign lo_d[LOFF +: LW] = en ? lo_new : lo_q[LOFF +: LW];
        end else begin : g_final
            logic             ovf_new;
            logic [WIDTH-1:0] res;

            // Carry into the MSB is recovered from the MSB sum bit itself.
            assign ovf_new = sa[SEG-1] ^ sb[SEG-1] ^ ss[SEG-1] ^ sco;
`ifdef CLA_SAT_EN
            assign res = !ovf_new  ? lo_new :
                         sa[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
            assign res = lo_new;
`endif
            assign lo_d[LOFF +: LW] = en ? res : lo_q[LOFF +: LW];
            assign ov_d             = en ? ovf_new : ov_q;
        end
    end

    if (STAGES == 1) begin : g_no_skew
        assign opa_d = opa_q;
        assign opb_d = opb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            lo_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            if (advance) begin
                vld_q <= vld_d;
            end
            cy_q  <= cy_d;
            lo_q  <= lo_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            ov_q  <= ov_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = lo_q[LO_BITS-1 -: WIDTH];
    assign bus.carry_out = cy_q[STAGES-1];
    assign bus.overflow  = ov_q;
endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the FIR datapath. It replaces fixed-width combinational adders on wide accumulate paths.
- Operand width is split into STAGES equal segments. Each segment is a BLOCK-grouped lookahead adder, with a register between segments.
- A valid/ready handshake lets the adder stall with downstream tap logic.

Parameters:
WIDTH, 32, operand/sum width in bits; must be divisible by STAGES
STAGES, 2, number of pipeline segments (1..8); latency in cycles
BLOCK, 4, lookahead group size inside a segment (2-level generate/propagate as in the 4-bit generator)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry in (borrow-not in subtract mode)
sub  input  1  1 = A - B, 0 = A + B
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
carry_out  output  1  carry out of MSB
overflow  output  1  signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
- Reset (async, any cycle):
  - all stage valid bits, sum, carry_out and overflow go to 0
  - in_ready = 1 after reset deasserts
  - beats in flight are discarded, with no partial output
- Operands and carry:
  - effective B = sub ? ~b : b
  - effective cin = sub ? ~carry_in : carry_in
  - so sub=1 with carry_in=0 gives A-B; chaining borrow-not gives multiword subtract
- Segment width SEG = WIDTH/STAGES.
- Stage k computes bits [k*SEG +: SEG] using the carry registered from stage k-1 (stage 0 uses effective cin).
  - Upper operand segments travel in skew registers.
  - Completed lower sum segments travel in deskew registers.
  - All segments of one beat emerge together.
- Latency: a beat accepted at edge t appears on out_valid/sum after edge t+STAGES-1. Result is registered; at STAGES=1, output is one cycle after accept.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance
  - the whole pipeline shifts only on advance
  - a transfer occurs when in_valid & in_ready
  - bubbles (stage valid=0) propagate normally; holes are not compressed
  - when advance=0 all stage registers, including sum/carry_out/overflow, hold
- Output rules:
  - sum, carry_out and overflow are stable while out_valid & !out_ready
  - values while out_valid=0 are don't-care, but held to last value (no X)
- Throughput: one beat per cycle when out_ready is held high.
- Boundaries:
  - carry chain wraps modulo 2^WIDTH
  - all-ones + 1 gives sum 0, carry_out 1, overflow 0
  - in_valid with in_ready=0 is not accepted; the source must hold
  - simultaneous accept and output in one cycle is legal

Optional Feature:
CLA_SAT_EN
- Defined: sum saturates as signed two's complement.
  - positive overflow gives 0x7F..F
  - negative overflow gives 0x80..0
  - overflow still reports the raw condition; carry_out is unchanged
  - saturation is applied in the final stage with no added latency
- Undefined: sum wraps; no saturation logic is present.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1, a=0x0000FFFF, b=1, sub=0, cin=0 -> after 2 cycles sum=0x00010000, carry_out=0, overflow=0 (carry crosses the segment boundary).
- a=0xFFFFFFFF, b=1, add -> sum=0, carry_out=1, overflow=0; a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1 (with CLA_SAT_EN: sum=0x7FFFFFFF).
- sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, carry_out=0; a=7, b=5 -> sum=2, carry_out=1.
- Back-to-back beats 1..8 (a=i, b=i), out_ready low for 3 cycles mid-stream -> in_ready low while stalled, outputs 2,4,..,16 in order, no loss or duplication, sum held during stall.
- Assert rst mid-stream with 2 beats in flight -> out_valid=0 and sum=0 immediately (async); first beat after release appears at correct latency.
- Randomised 10k beats at STAGES=1,2,4 and BLOCK=2,4 against a behavioural a+b+cin model -> zero mismatches.
